// File: rtl/bram_frame_ctrl.sv
// Store-then-forward frame buffer sequencer: fills a BRAM with one frame,
// then drains it in raster order with x/y/last tagging.
module bram_frame_ctrl #(
  parameter int WIDTH      = 720,
  parameter int HEIGHT     = 540,
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [15:0]           out_x,
  output logic [15:0]           out_y,
  output logic                  out_last,
  output logic                  bram_wr_en,
  output logic [ADDR_WIDTH-1:0] bram_wr_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic [ADDR_WIDTH-1:0] bram_rd_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic                  busy
);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(WIDTH * HEIGHT - 1);
  localparam logic [15:0] XMAX = 16'(WIDTH - 1);

  state_e                state;
  state_e                state_nx;
  logic [ADDR_WIDTH-1:0] wr_cnt;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic [15:0]           x;
  logic [15:0]           y;
  logic                  rd_done;
  logic                  load;
  logic                  rd_last;
  logic                  wr_last;
  logic                  out_fire;

  assign wr_last  = wr_cnt == LAST;
  assign rd_last  = rd_cnt == LAST;
  assign out_fire = out_valid & out_ready;
  assign load     = (state == DRAIN) & ~rd_done
                  & (~out_valid | out_ready);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FILL:  if (in_valid && wr_last) state_nx = DRAIN;
      DRAIN: if (out_fire && out_last) state_nx = FILL;
    endcase
  end

  always_comb begin
    in_ready     = state == FILL;
    busy         = state == DRAIN;
    bram_wr_en   = in_valid & in_ready;
    bram_din     = in_data;
    bram_wr_addr = wr_cnt;
    bram_rd_addr = rd_cnt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_cnt <= '0;
    end else if (bram_wr_en) begin
      wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
    end
  end

  // Read side: one load per free output slot; rd_done stops the reader
  // after the last pixel until the final handshake returns us to FILL.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_cnt    <= '0;
      x         <= '0;
      y         <= '0;
      rd_done   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_data  <= bram_dout;
      out_valid <= 1'b1;
      out_x     <= x;
      out_y     <= y;
      out_last  <= rd_last;
      if (rd_last) begin
        rd_done <= 1'b1;
        rd_cnt  <= '0;
        x       <= '0;
        y       <= '0;
      end else begin
        rd_cnt <= rd_cnt + 1'b1;
        if (x == XMAX) begin
          x <= '0;
          y <= y + 16'd1;
        end else begin
          x <= x + 16'd1;
        end
      end
    end else if (out_fire) begin
      out_valid <= 1'b0;
      if (out_last) rd_done <= 1'b0;
    end
  end

endmodule
